syn_fifo_flex: RTL and testbench

Parametrised synchronous FIFO, successor to the fixed 8-bit × 16 FIFO. It adds configurable data width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It also selects at build time between a registered-read mode and a first-word-fall-through (FWFT) mode. It sits between same-clock producer and consumer blocks as the standard elastic buffer.

---
 rtl/syn_fifo_flex.sv | 74 +++++++
 tb/tb_syn_fifo_flex.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/syn_fifo_flex.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags, sticky
// error flags and a build-time choice of registered-read or FWFT output.
module syn_fifo_flex #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int           AW  = $clog2(DEPTH);
    localparam logic [AW:0]  AF  = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]  AE  = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0]  ONE = (AW+1)'(1);

    logic [AW:0]       wptr, rptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok, rd_ok;

    // Status is decoded from the registered pointers only, never from wr/rd.
    assign count        = wptr - rptr;
    assign empty        = (wptr == rptr);
    assign full         = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign almost_full  = (count >= AF);
    assign almost_empty = (count <= AE);

    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + ONE;
            if (rd_ok) rptr <= rptr + ONE;
            if (wr && full)  overflow  <= 1'b1;
            if (rd && empty) underflow <= 1'b1;
        end
    end

    // Storage is not reset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wptr[AW-1:0]] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rptr[AW-1:0]];
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst)        dout_q <= '0;
                else if (rd_ok) dout_q <= mem[rptr[AW-1:0]];
            end
            assign data_out = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_syn_fifo_flex.sv
// Directed bench: default registered-read FIFO plus a 32x4 FWFT instance.
module tb_syn_fifo_flex;
    logic       clk = 1'b0;
    logic       rst, wr, rd;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic        f_wr, f_rd;
    logic [31:0] f_din, f_dout;
    logic        f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0]  f_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    syn_fifo_flex dut (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    syn_fifo_flex #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr(f_wr), .data_in(f_din), .rd(f_rd),
        .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0;
        f_wr = 1'b0; f_rd = 1'b0; f_din = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (empty !== 1'b1)        begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got %b want 1", almost_empty); end
        n_cmp++; if (count !== 5'd0)        begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (data_out !== 8'h00)    begin n_err++; $display("FAIL reset_dout got %h want 00", data_out); end
        n_cmp++; if (full !== 1'b0)         begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (overflow !== 1'b0)     begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_cmp++; if (almost_full !== 1'b0)  begin n_err++; $display("FAIL reset_af got %b want 0", almost_full); end
    endtask

    task automatic test_fill();
        logic [4:0] c;
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data_in = 8'(i);
            tick();
            c = 5'(i + 1);
            n_cmp++; if (count !== c) begin n_err++; $display("FAIL fill_count got %0d want %0d", count, c); end
            n_cmp++; if (almost_empty !== (c <= 5'd2)) begin n_err++; $display("FAIL fill_ae at %0d got %b", c, almost_empty); end
            n_cmp++; if (almost_full !== (c >= 5'd14)) begin n_err++; $display("FAIL fill_af at %0d got %b", c, almost_full); end
            n_cmp++; if (full !== (c == 5'd16))        begin n_err++; $display("FAIL fill_full at %0d got %b", c, full); end
        end
        data_in = 8'hAA;
        tick();
        wr = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_ovf got %b want 1", overflow); end
        n_cmp++; if (count !== 5'd16)   begin n_err++; $display("FAIL fill_ovf_count got %0d want 16", count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            rd = 1'b1;
            tick();
            n_cmp++; if (data_out !== 8'(i))       begin n_err++; $display("FAIL drain_data got %h want %h", data_out, 8'(i)); end
            n_cmp++; if (count !== 5'(15 - i))     begin n_err++; $display("FAIL drain_count got %0d want %0d", count, 15 - i); end
        end
        tick();
        rd = 1'b0;
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL drain_unf got %b want 1", underflow); end
        n_cmp++; if (data_out !== 8'h0F) begin n_err++; $display("FAIL drain_hold got %h want 0f", data_out); end
        n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr = 1'b1; data_in = 8'(8'h10 + i); tick();
        end
        wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd = 1'b1; tick();
            n_cmp++; if (data_out !== 8'(8'h10 + i)) begin n_err++; $display("FAIL wrap_pre got %h want %h", data_out, 8'(8'h10 + i)); end
        end
        rd = 1'b0;
        // Prime one word so the concurrent phase never reads an empty FIFO.
        wr = 1'b1; data_in = 8'h80; tick();
        for (int k = 1; k <= 40; k++) begin
            wr = 1'b1; rd = 1'b1; data_in = 8'(8'h80 + k);
            tick();
            n_cmp++; if (data_out !== 8'(8'h80 + k - 1)) begin n_err++; $display("FAIL wrap_data got %h want %h", data_out, 8'(8'h80 + k - 1)); end
            n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL wrap_count got %0d want 1", count); end
        end
        wr = 1'b0; rd = 1'b0;
        n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL wrap_ovf got %b want 0", overflow); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL wrap_unf got %b want 0", underflow); end

        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data_in = 8'(8'h40 + i); tick();
        end
        wr = 1'b1; rd = 1'b1; data_in = 8'hEE;
        tick();
        wr = 1'b0; rd = 1'b0;
        n_cmp++; if (count !== 5'd15)    begin n_err++; $display("FAIL full_rw_count got %0d want 15", count); end
        n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL full_rw_ovf got %b want 1", overflow); end
        n_cmp++; if (data_out !== 8'h40) begin n_err++; $display("FAIL full_rw_data got %h want 40", data_out); end
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1; tick();
            n_cmp++; if (data_out !== 8'(8'h41 + i)) begin n_err++; $display("FAIL full_rw_drain got %h want %h", data_out, 8'(8'h41 + i)); end
        end
        rd = 1'b0;
    endtask

    task automatic test_reset_mid();
        n_cmp++; if (count !== 5'd7) begin n_err++; $display("FAIL mid_pre_count got %0d want 7", count); end
        rst = 1'b1; wr = 1'b1; rd = 1'b1; data_in = 8'h55;
        tick();
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        n_cmp++; if (count !== 5'd0)     begin n_err++; $display("FAIL mid_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL mid_empty got %b want 1", empty); end
        n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL mid_ovf got %b want 0", overflow); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL mid_unf got %b want 0", underflow); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL mid_dout got %h want 00", data_out); end
        tick();
        n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL mid_not_stored got empty=%b want 1", empty); end
        wr = 1'b1; data_in = 8'h33; tick(); wr = 1'b0;
        rd = 1'b1; tick(); rd = 1'b0;
        n_cmp++; if (data_out !== 8'h33) begin n_err++; $display("FAIL mid_after got %h want 33", data_out); end
        n_cmp++; if (count !== 5'd0)     begin n_err++; $display("FAIL mid_after_count got %0d want 0", count); end
    endtask

    task automatic test_fwft();
        n_cmp++; if (f_dout !== 32'h0)  begin n_err++; $display("FAIL fwft_idle got %h want 0", f_dout); end
        f_wr = 1'b1; f_din = 32'hDEADBEEF;
        tick();
        f_wr = 1'b0;
        n_cmp++; if (f_dout !== 32'hDEADBEEF) begin n_err++; $display("FAIL fwft_show got %h want deadbeef", f_dout); end
        n_cmp++; if (f_count !== 3'd1)        begin n_err++; $display("FAIL fwft_count got %0d want 1", f_count); end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        n_cmp++; if (f_dout !== 32'h0)  begin n_err++; $display("FAIL fwft_pop got %h want 0", f_dout); end
        n_cmp++; if (f_empty !== 1'b1)  begin n_err++; $display("FAIL fwft_empty got %b want 1", f_empty); end
        n_cmp++; if (f_unf !== 1'b0)    begin n_err++; $display("FAIL fwft_unf got %b want 0", f_unf); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_reset_mid();
        test_fwft();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
